// File: rtl/l1_line_responder_pkg.sv
// Shared types and constants for the L1 line responder: FSM states, beat
// indexing and line-address alignment.
package l1_line_responder_pkg;

   localparam int LINE_OFFSET_BITS = 5;
   localparam int DEF_LINE_WIDTH   = 256;
   localparam int DEF_BEAT_WIDTH   = 64;
   localparam int DEF_ADDR_WIDTH   = 32;
   localparam int BEATS            = DEF_LINE_WIDTH / DEF_BEAT_WIDTH;
   localparam int BEAT_IDX_W       = $clog2(BEATS);

   typedef logic [BEAT_IDX_W-1:0] beat_idx_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_BURST = 2'd1,
      WR_BURST = 2'd2,
      DONE     = 2'd3
   } state_e;

   function automatic logic [DEF_ADDR_WIDTH-1:0] align_line_addr(
      input logic [DEF_ADDR_WIDTH-1:0] addr
   );
      return {addr[DEF_ADDR_WIDTH-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
   endfunction

endpackage

// File: rtl/l1_line_responder_burst_beat_buffer.sv
// Line-wide register: whole-line load for writebacks, per-beat fill for reads,
// and a beat-select mux feeding the narrow write bus.
module burst_beat_buffer #(
   parameter int LINE_WIDTH = 256,
   parameter int BEAT_WIDTH = 64,
   parameter int IDX_W      = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_line,
   input  logic [LINE_WIDTH-1:0] line_in,
   input  logic                  beat_we,
   input  logic [IDX_W-1:0]      beat_idx,
   input  logic [BEAT_WIDTH-1:0] beat_in,
   output logic [LINE_WIDTH-1:0] line_out,
   output logic [BEAT_WIDTH-1:0] beat_out
);

   logic [LINE_WIDTH-1:0] line_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_q <= '0;
      end else if (load_line) begin
         line_q <= line_in;
      end else if (beat_we) begin
         line_q[beat_idx*BEAT_WIDTH +: BEAT_WIDTH] <= beat_in;
      end
   end

   assign line_out = line_q;
   assign beat_out = line_q[beat_idx*BEAT_WIDTH +: BEAT_WIDTH];

endmodule

// File: rtl/l1_line_responder.sv
// Line-width adaptor between the L1 D-cache and a beat-wide physical memory:
// each line request becomes a fixed burst followed by a one-cycle completion.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for pmem_read / pmem_write (write wins if both)
// RD_BURST | mem_read held; each mem_resp fills one beat of the buffer
// WR_BURST | mem_write held; each mem_resp retires one latched beat
// DONE     | pmem_resp pulse for one cycle, then back to IDLE
module l1_line_responder
   import l1_line_responder_pkg::*;
#(
   parameter int LINE_WIDTH = DEF_LINE_WIDTH,
   parameter int BEAT_WIDTH = DEF_BEAT_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pmem_read,
   input  logic                  pmem_write,
   input  logic [ADDR_WIDTH-1:0] pmem_address,
   input  logic [LINE_WIDTH-1:0] pmem_wdata,
   output logic [LINE_WIDTH-1:0] pmem_rdata,
   output logic                  pmem_resp,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [BEAT_WIDTH-1:0] mem_wdata,
   input  logic [BEAT_WIDTH-1:0] mem_rdata,
   input  logic                  mem_resp
);

   state_e                state_q, state_d;
   beat_idx_t             cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  load_line, beat_we;
   logic [BEAT_WIDTH-1:0] beat_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
      end
   end

   // The counter wraps naturally from BEATS-1 to 0 on the last beat.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      load_line = 1'b0;
      beat_we   = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      pmem_resp = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pmem_write) begin
               addr_d    = align_line_addr(pmem_address);
               cnt_d     = '0;
               load_line = 1'b1;
               state_d   = WR_BURST;
            end else if (pmem_read) begin
               addr_d  = align_line_addr(pmem_address);
               cnt_d   = '0;
               state_d = RD_BURST;
            end
         end
         RD_BURST: begin
            mem_read = 1'b1;
            if (mem_resp) begin
               beat_we = 1'b1;
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == beat_idx_t'(BEATS-1)) state_d = DONE;
            end
         end
         WR_BURST: begin
            mem_write = 1'b1;
            if (mem_resp) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == beat_idx_t'(BEATS-1)) state_d = DONE;
            end
         end
         DONE: begin
            pmem_resp = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_address = (mem_read || mem_write) ? addr_q : '0;
   assign mem_wdata   = mem_write ? beat_out : '0;

   burst_beat_buffer #(
      .LINE_WIDTH (LINE_WIDTH),
      .BEAT_WIDTH (BEAT_WIDTH),
      .IDX_W      (BEAT_IDX_W)
   ) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_line (load_line),
      .line_in   (pmem_wdata),
      .beat_we   (beat_we),
      .beat_idx  (cnt_q),
      .beat_in   (mem_rdata),
      .line_out  (pmem_rdata),
      .beat_out  (beat_out)
   );

endmodule

// File: tb/tb_l1_line_responder.sv
// Scoreboard bench for l1_line_responder: expected lines/beats are queued when
// a request is driven and consumed by a negedge monitor as the DUT responds.
module tb_l1_line_responder;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         pmem_read, pmem_write;
   logic [31:0]  pmem_address;
   logic [255:0] pmem_wdata, pmem_rdata;
   logic         pmem_resp;
   logic [31:0]  mem_address;
   logic         mem_read, mem_write;
   logic [63:0]  mem_wdata, mem_rdata;
   logic         mem_resp;

   typedef struct {
      logic         is_read;
      logic [255:0] line;
   } exp_t;

   exp_t        exp_q[$];
   logic [63:0] wq[$];
   exp_t        mon_e;
   logic [31:0] exp_addr = '0;
   logic        saw_mem_read = 1'b0;
   int          vectors = 0;
   int          miscompares = 0;
   int          resp_cnt = 0;
   int          txn_cnt = 0;

   always #5 clk = ~clk;

   l1_line_responder dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp),
      .mem_address  (mem_address),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_resp     (mem_resp)
   );

   task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_read) saw_mem_read = 1'b1;
         if (mem_read && mem_write) check_val("rd_wr_exclusive", 1, 0);
         if (mem_read || mem_write) check_val("mem_address", mem_address, exp_addr);
         if (mem_write && mem_resp) begin
            if (wq.size() == 0) check_val("wdata_extra_beat", 1, 0);
            else check_val("mem_wdata", mem_wdata, wq.pop_front());
         end
         if (pmem_resp) begin
            resp_cnt++;
            if (exp_q.size() == 0) check_val("resp_unexpected", 1, 0);
            else begin
               mon_e = exp_q.pop_front();
               if (mon_e.is_read) check_val("pmem_rdata", pmem_rdata, mon_e.line);
            end
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check_val({tag, "_outs"},
                {pmem_resp, mem_read, mem_write, mem_wdata, mem_address}, '0);
      check_val({tag, "_rdata"}, pmem_rdata, '0);
   endtask

   task automatic run_read(input logic [31:0] addr, input logic [255:0] line);
      exp_q.push_back('{1'b1, line});
      exp_addr     = addr & ~32'h1f;
      txn_cnt++;
      pmem_read    = 1'b1;
      pmem_address = addr;
      tick();
      pmem_read    = 1'b0;
      pmem_address = 32'hdead_beef;
      for (int b = 0; b < 4; b++) begin
         mem_resp  = 1'b1;
         mem_rdata = line[b*64 +: 64];
         @(negedge clk);
         check_val("rd_mem_read", mem_read, 1);
         check_val("rd_early_resp", pmem_resp, 0);
         tick();
      end
      mem_resp  = 1'b0;
      mem_rdata = '0;
      @(negedge clk);
      check_val("rd_resp_cycle5", pmem_resp, 1);
      check_val("rd_mem_read_drop", mem_read, 0);
      tick();
      @(negedge clk);
      check_val("rd_resp_single", pmem_resp, 0);
   endtask

   task automatic run_write(input logic [31:0] addr, input logic [255:0] line,
                            input logic [15:0] pat, input int n, input bit also_read);
      exp_q.push_back('{1'b0, line});
      for (int b = 0; b < 4; b++) wq.push_back(line[b*64 +: 64]);
      exp_addr     = addr & ~32'h1f;
      txn_cnt++;
      pmem_write   = 1'b1;
      pmem_read    = also_read;
      pmem_address = addr;
      pmem_wdata   = line;
      tick();
      pmem_write   = 1'b0;
      pmem_read    = 1'b0;
      pmem_wdata   = ~line;
      for (int i = 0; i < n; i++) begin
         mem_resp = pat[i];
         @(negedge clk);
         check_val("wr_mem_write", mem_write, 1);
         check_val("wr_early_resp", pmem_resp, 0);
         tick();
      end
      mem_resp = 1'b0;
      @(negedge clk);
      check_val("wr_resp", pmem_resp, 1);
      check_val("wr_mem_write_drop", mem_write, 0);
      tick();
      @(negedge clk);
      check_val("wr_resp_single", pmem_resp, 0);
      check_val("wr_idle_mem_write", mem_write, 0);
   endtask

   initial begin
      rst_n        = 1'b0;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;
      mem_rdata    = '0;
      mem_resp     = 1'b0;
      repeat (2) tick();
      check_all_zero("reset");
      rst_n = 1'b1;
      tick();

      run_read(32'h0000_1234, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

      run_write(32'h0000_8a5f, {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
                16'h0059, 7, 1'b0);

      saw_mem_read = 1'b0;
      run_write(32'h0001_0000, {64'h0123_4567_89ab_cdef, 64'hfeed_face_cafe_beef,
                                64'h0f0f_0f0f_f0f0_f0f0, 64'h5a5a_a5a5_5a5a_a5a5},
                16'h000f, 4, 1'b1);
      check_val("simul_no_mem_read", saw_mem_read, 0);

      exp_addr     = 32'h0000_4000;
      pmem_read    = 1'b1;
      pmem_address = 32'h0000_4010;
      tick();
      pmem_read = 1'b0;
      for (int b = 0; b < 2; b++) begin
         mem_resp  = 1'b1;
         mem_rdata = 64'h9999_0000_0000_0000 | 64'(b);
         tick();
      end
      rst_n = 1'b0;
      #1;
      check_all_zero("reset_mid_read");
      mem_resp = 1'b0;
      begin
         int cnt_before;
         cnt_before = resp_cnt;
         repeat (2) tick();
         rst_n = 1'b1;
         repeat (3) tick();
         check_val("reset_no_resp", resp_cnt, cnt_before);
      end
      run_read(32'h0000_4010, {64'h7777_0000_0000_0004, 64'h7777_0000_0000_0003,
                               64'h7777_0000_0000_0002, 64'h7777_0000_0000_0001});

      run_read(32'h0000_2040, {64'h1234_5678_0000_aaaa, 64'h8765_4321_1111_bbbb,
                               64'h0000_ffff_2222_cccc, 64'hffff_0000_3333_dddd});
      run_write(32'h0000_2040, {64'h0000_0000_0000_0004, 64'h0000_0000_0000_0003,
                                64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001},
                16'h000f, 4, 1'b0);

      mem_resp  = 1'b1;
      mem_rdata = 64'hbad0_bad0_bad0_bad0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_val("idle_spurious", {mem_read, mem_write, pmem_resp}, 3'b000);
         tick();
      end
      mem_resp = 1'b0;
      tick();

      check_val("resp_count", resp_cnt, txn_cnt);
      check_val("exp_q_drained", exp_q.size(), 0);
      check_val("wq_drained", wq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
